// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neuron-layer datapath: default layer geometry,
// the neuron result width and the layer_feeder sequencer state encoding.
// ---------------------------------------------------------------------------
package nn_pkg;

  // Default layer geometry (overridable per instance)
  localparam int DEF_IN_WIDTH    = 4;
  localparam int DEF_NUM_INPUTS  = 784;
  localparam int DEF_NUM_NEURONS = 32;

  // Width of one neuron's quantised output
  localparam int RESULT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/act_buffer.sv
// ---------------------------------------------------------------------------
// act_buffer
// Local activation store for one layer: DEPTH x WIDTH, one write port and one
// synchronous read port with 1-cycle read latency. Contents are never
// cleared by reset; only the read-data register is.
//
// Ports
//   clk, rst      clock, synchronous active-high reset (read register only)
//   i_wr_en       write strobe
//   i_wr_addr     write address; addresses >= DEPTH are dropped
//   i_wr_data     write data
//   i_rd_en       read strobe
//   i_rd_addr     read address
//   o_rd_data     read data, valid the cycle after i_rd_en, held otherwise
// ---------------------------------------------------------------------------
module act_buffer
  import nn_pkg::*;
#(
  parameter  int WIDTH = DEF_IN_WIDTH,
  parameter  int DEPTH = DEF_NUM_INPUTS,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  // Storage array; the address range check matters when DEPTH is not a
  // power of two and the address bus can encode rows that do not exist.
  always_ff @(posedge clk) begin
    if (i_wr_en && (int'(i_wr_addr) < DEPTH)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value between reads so the consumer
  // sees a stable activation when no pair is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/layer_feeder.sv
// ---------------------------------------------------------------------------
// layer_feeder
// Sequencer upstream of a single shared neuron. Buffers one layer's input
// activations, reads weights from an external synchronous weight memory,
// streams (activation, weight) pairs at one pair per cycle for NUM_NEURONS
// consecutive neurons, and writes each neuron's result to an output port.
//
// Optional feature: define LAYER_FEEDER_PAUSE_EN to add the i_pause input,
// which stalls weight/activation issue while high in the ISSUE state.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   i_act_wr_en/addr/data activation buffer write port (ignored while busy)
//   i_start              1-cycle pulse starting a layer (ignored while busy)
//   i_pause              issue stall (LAYER_FEEDER_PAUSE_EN builds only)
//   o_busy               high from the cycle after start through o_done
//   o_done               1-cycle pulse with the final result write
//   o_w_rd_en/addr       weight memory read, address n*NUM_INPUTS + i
//   i_w_rd_data          weight, valid the cycle after o_w_rd_en
//   o_nrn_data/weight    pair to the neuron, held while o_nrn_valid is low
//   o_nrn_valid          pair valid to the neuron
//   i_nrn_result/_valid  neuron output
//   o_out_wr_en/addr/data result write port (address = neuron index)
// ---------------------------------------------------------------------------
module layer_feeder
  import nn_pkg::*;
#(
  parameter  int IN_WIDTH    = DEF_IN_WIDTH,
  parameter  int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter  int NUM_NEURONS = DEF_NUM_NEURONS,
  localparam int A_W         = $clog2(NUM_INPUTS),
  localparam int N_W         = $clog2(NUM_NEURONS),
  localparam int W_W         = $clog2(NUM_INPUTS * NUM_NEURONS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_act_wr_en,
  input  logic [A_W-1:0]      i_act_wr_addr,
  input  logic [IN_WIDTH-1:0] i_act_wr_data,
  input  logic                i_start,
`ifdef LAYER_FEEDER_PAUSE_EN
  input  logic                i_pause,
`endif
  output logic                o_busy,
  output logic                o_done,
  output logic                o_w_rd_en,
  output logic [W_W-1:0]      o_w_rd_addr,
  input  logic [IN_WIDTH-1:0] i_w_rd_data,
  output logic [IN_WIDTH-1:0] o_nrn_data,
  output logic [IN_WIDTH-1:0] o_nrn_weight,
  output logic                o_nrn_valid,
  input  logic [RESULT_W-1:0] i_nrn_result,
  input  logic                i_nrn_result_valid,
  output logic                o_out_wr_en,
  output logic [N_W-1:0]      o_out_wr_addr,
  output logic [RESULT_W-1:0] o_out_wr_data
);

  localparam logic [A_W-1:0] I_LAST = A_W'(NUM_INPUTS - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(NUM_NEURONS - 1);

  feeder_state_t       r_state;
  logic [A_W-1:0]      r_i;
  logic [N_W-1:0]      r_n;
  logic [W_W-1:0]      r_w_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_nrn_valid;
  logic [IN_WIDTH-1:0] r_weight_hold;
  logic [N_W-1:0]      r_res_cnt;
  logic                r_out_wr_en;
  logic [N_W-1:0]      r_out_wr_addr;
  logic [RESULT_W-1:0] r_out_wr_data;

  logic                w_pause;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_res_accept;
  logic                w_act_wr_en;
  logic [IN_WIDTH-1:0] w_buf_rd_data;

`ifdef LAYER_FEEDER_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  // A read is issued combinationally so that a pause seen in a cycle
  // suppresses that very cycle's read.
  assign w_issue      = (r_state == ISSUE) && !w_pause;
  assign w_last_issue = w_issue && (r_i == I_LAST) && (r_n == N_LAST);

  // Results are counted in ISSUE too: earlier neurons finish while later
  // neurons are still being streamed.
  assign w_res_accept = i_nrn_result_valid && (r_state != IDLE);

  // The buffer is frozen for the whole busy window, including the done cycle.
  assign w_act_wr_en  = i_act_wr_en && !r_busy;

  act_buffer #(
    .WIDTH (IN_WIDTH),
    .DEPTH (NUM_INPUTS)
  ) u_act_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_act_wr_en),
    .i_wr_addr (i_act_wr_addr),
    .i_wr_data (i_act_wr_data),
    .i_rd_en   (w_issue),
    .i_rd_addr (r_i),
    .o_rd_data (w_buf_rd_data)
  );

  // Layer sequencer. busy stays high through the done cycle (state is
  // already IDLE then) and drops one cycle later, so a start coinciding
  // with done is still treated as arriving while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_i      <= '0;
      r_n      <= '0;
      r_w_addr <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start && !r_busy) begin
            r_state <= ISSUE;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        ISSUE: begin
          if (w_issue) begin
            r_w_addr <= w_last_issue ? '0 : r_w_addr + W_W'(1);
            if (r_i == I_LAST) begin
              r_i <= '0;
              r_n <= (r_n == N_LAST) ? '0 : r_n + N_W'(1);
            end else begin
              r_i <= r_i + A_W'(1);
            end
            if (w_last_issue) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (w_res_accept && (r_res_cnt == N_LAST)) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Issue-to-pair pipeline stage. The weight memory output is only valid
  // for one cycle, so its value is captured while a pair is live and
  // replayed afterwards to keep o_nrn_weight stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nrn_valid   <= 1'b0;
      r_weight_hold <= '0;
    end else begin
      r_nrn_valid <= w_issue;
      if (r_nrn_valid) begin
        r_weight_hold <= i_w_rd_data;
      end
    end
  end

  // Result capture. The counter wraps to 0 after the last neuron, so it is
  // ready for the next layer without an explicit clear on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_cnt     <= '0;
      r_out_wr_en   <= 1'b0;
      r_out_wr_addr <= '0;
      r_out_wr_data <= '0;
    end else begin
      r_out_wr_en <= w_res_accept;
      if (w_res_accept) begin
        r_out_wr_addr <= r_res_cnt;
        r_out_wr_data <= i_nrn_result;
        r_res_cnt     <= (r_res_cnt == N_LAST) ? '0 : r_res_cnt + N_W'(1);
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_w_rd_en     = w_issue;
  assign o_w_rd_addr   = r_w_addr;
  assign o_nrn_valid   = r_nrn_valid;
  assign o_nrn_data    = w_buf_rd_data;
  assign o_nrn_weight  = r_nrn_valid ? i_w_rd_data : r_weight_hold;
  assign o_out_wr_en   = r_out_wr_en;
  assign o_out_wr_addr = r_out_wr_addr;
  assign o_out_wr_data = r_out_wr_data;

endmodule

// File: tb/tb_layer_feeder.sv
// ---------------------------------------------------------------------------
// tb_layer_feeder
// Bench for layer_feeder with a small layer (5 inputs, 2 neurons). Five
// inputs let the 3-bit activation address encode out-of-range rows 5..7.
// Surrounding models: a 1-cycle synchronous weight memory and a behavioural
// neuron (accumulate, arithmetic shift by 6, ReLU, clamp to 4 bits).
// Expected results come from the layer's arithmetic over the reference
// activation/weight arrays; expected timing comes from the start cycle.
// ---------------------------------------------------------------------------
module tb_layer_feeder;

  localparam int IW    = 4;
  localparam int NI    = 5;
  localparam int NN    = 2;
  localparam int SHIFT = 6;
  localparam int A_W   = $clog2(NI);
  localparam int N_W   = $clog2(NN);
  localparam int W_W   = $clog2(NI * NN);
  localparam int LAT   = NN * NI + 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           act_wr_en = 1'b0;
  logic [A_W-1:0] act_wr_addr = '0;
  logic [IW-1:0]  act_wr_data = '0;
  logic           start = 1'b0;
  logic           pause = 1'b0;
  logic           busy, done, w_rd_en, nrn_valid, out_wr_en;
  logic [W_W-1:0] w_rd_addr;
  logic [IW-1:0]  w_rd_data = '0;
  logic [IW-1:0]  nrn_data, nrn_weight;
  logic [3:0]     nrn_result;
  logic           nrn_result_valid;
  logic [N_W-1:0] out_wr_addr;
  logic [3:0]     out_wr_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit timed_out = 1'b0;

  logic [IW-1:0] act_ref [NI];
  logic [IW-1:0] wmem [NI*NN];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_feeder #(
    .IN_WIDTH    (IW),
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_act_wr_en        (act_wr_en),
    .i_act_wr_addr      (act_wr_addr),
    .i_act_wr_data      (act_wr_data),
    .i_start            (start),
`ifdef LAYER_FEEDER_PAUSE_EN
    .i_pause            (pause),
`endif
    .o_busy             (busy),
    .o_done             (done),
    .o_w_rd_en          (w_rd_en),
    .o_w_rd_addr        (w_rd_addr),
    .i_w_rd_data        (w_rd_data),
    .o_nrn_data         (nrn_data),
    .o_nrn_weight       (nrn_weight),
    .o_nrn_valid        (nrn_valid),
    .i_nrn_result       (nrn_result),
    .i_nrn_result_valid (nrn_result_valid),
    .o_out_wr_en        (out_wr_en),
    .o_out_wr_addr      (out_wr_addr),
    .o_out_wr_data      (out_wr_data)
  );

  // Synchronous weight memory with one cycle of read latency
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem[w_rd_addr];
  end

  function automatic logic [3:0] neuron_fn(input int s);
    int v;
    v = s >>> SHIFT;
    if (v < 0) v = 0;
    if (v > 15) v = 15;
    return 4'(v);
  endfunction

  function automatic logic [3:0] ref_result(input int n);
    int s;
    s = 0;
    for (int i = 0; i < NI; i++) s += int'(act_ref[i]) * int'($signed(wmem[n*NI+i]));
    return neuron_fn(s);
  endfunction

  // Behavioural neuron: result one cycle after its last pair, then self-clears
  int n_acc = 0;
  int n_cnt = 0;
  logic [3:0] n_res = '0;
  logic n_val = 1'b0;
  logic inj_v = 1'b0;
  logic [3:0] inj_d = '0;
  always @(posedge clk) begin
    if (rst) begin
      n_acc = 0; n_cnt = 0; n_val <= 1'b0; n_res <= '0;
    end else begin
      n_val <= 1'b0;
      if (nrn_valid) begin
        n_acc = n_acc + int'(nrn_data) * int'($signed(nrn_weight));
        if (n_cnt == NI - 1) begin
          n_res <= neuron_fn(n_acc); n_val <= 1'b1; n_acc = 0; n_cnt = 0;
        end else begin
          n_cnt++;
        end
      end
    end
  end
  assign nrn_result_valid = n_val | inj_v;
  assign nrn_result       = inj_v ? inj_d : n_res;

  // Event logs, sampled mid-cycle
  int rd_c[$], rd_a[$], nv_c[$], pr_d[$], pr_w[$], wr_c[$], wr_a[$], wr_d[$], dn_c[$], bz_c[$];
  always @(negedge clk) begin
    if (w_rd_en)   begin rd_c.push_back(cyc); rd_a.push_back(int'(w_rd_addr)); end
    if (nrn_valid) begin nv_c.push_back(cyc); pr_d.push_back(int'(nrn_data)); pr_w.push_back(int'(nrn_weight)); end
    if (out_wr_en) begin wr_c.push_back(cyc); wr_a.push_back(int'(out_wr_addr)); wr_d.push_back(int'(out_wr_data)); end
    if (done) dn_c.push_back(cyc);
    if (busy) bz_c.push_back(cyc);
  end

  task automatic clear_logs();
    rd_c.delete(); rd_a.delete(); nv_c.delete(); pr_d.delete(); pr_w.delete();
    wr_c.delete(); wr_a.delete(); wr_d.delete(); dn_c.delete(); bz_c.delete();
  endtask

  // Write one activation while idle; the reference follows the storage rule
  task automatic write_act(input int addr, input int data);
    @(posedge clk); #1;
    act_wr_en = 1'b1; act_wr_addr = A_W'(addr); act_wr_data = IW'(data);
    @(posedge clk); #1;
    act_wr_en = 1'b0;
    if (addr < NI) act_ref[addr] = IW'(data);
  endtask

  // Start a layer at t0 and drive per-cycle side stimulus (cycle offsets from t0)
  task automatic run_layer(input int pause_at, input int pause_len, input int restart_at,
                           input int wr_at, input int wr_addr, input int wr_data);
    clear_logs();
    @(posedge clk); #1;
    start = 1'b1; t0 = cyc;
    timed_out = 1'b1;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      start       = (k == restart_at);
      act_wr_en   = (k == wr_at);
      act_wr_addr = A_W'(wr_addr);
      act_wr_data = IW'(wr_data);
      pause       = (k >= pause_at) && (k < pause_at + pause_len);
      if (dn_c.size() > 0 && (t0 + k) > dn_c[0] + 3) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; act_wr_en = 1'b0; pause = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if ({busy, done, w_rd_en, nrn_valid, out_wr_en} !== 5'b0) begin
      failures++; $display("[TB] FAIL reset_ctrl got=%b exp=00000", {busy, done, w_rd_en, nrn_valid, out_wr_en}); end
    checks++; if ({w_rd_addr, out_wr_addr, out_wr_data} !== '0) begin
      failures++; $display("[TB] FAIL reset_addr got=%0h exp=0", {w_rd_addr, out_wr_addr, out_wr_data}); end
    checks++; if ({nrn_data, nrn_weight} !== '0) begin
      failures++; $display("[TB] FAIL reset_nrn got=%0h exp=0", {nrn_data, nrn_weight}); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, w_rd_en} !== 2'b00) begin
      failures++; $display("[TB] FAIL start_with_rst got=%b exp=00", {busy, w_rd_en}); end
  endtask

  // Acts all 15, weights all 7: full timing schedule plus results
  task automatic test_basic();
    for (int i = 0; i < NI; i++) write_act(i, 15);
    for (int k = 0; k < NI*NN; k++) wmem[k] = 4'd7;
    run_layer(0, 0, 0, 0, 0, 0);
    checks++; if (timed_out) begin failures++; $display("[TB] FAIL basic_timeout got=1 exp=0"); end
    checks++; if (rd_a.size() != NI*NN) begin
      failures++; $display("[TB] FAIL basic_rd_count got=%0d exp=%0d", rd_a.size(), NI*NN); end
    for (int k = 0; k < rd_a.size(); k++) begin
      checks++; if (rd_a[k] != k || rd_c[k] != t0 + 1 + k) begin
        failures++; $display("[TB] FAIL basic_rd[%0d] got=addr %0d@%0d exp=addr %0d@%0d", k, rd_a[k], rd_c[k] - t0, k, 1 + k); end
    end
    checks++; if (nv_c.size() != NI*NN) begin
      failures++; $display("[TB] FAIL basic_nv_count got=%0d exp=%0d", nv_c.size(), NI*NN); end
    for (int k = 0; k < nv_c.size(); k++) begin
      checks++; if (nv_c[k] != t0 + 2 + k || pr_d[k] != 15 || pr_w[k] != 7) begin
        failures++; $display("[TB] FAIL basic_pair[%0d] got=(%0d,%0d)@%0d exp=(15,7)@%0d", k, pr_d[k], pr_w[k], nv_c[k] - t0, 2 + k); end
    end
    checks++; if (wr_a.size() != NN) begin
      failures++; $display("[TB] FAIL basic_wr_count got=%0d exp=%0d", wr_a.size(), NN); end
    for (int k = 0; k < wr_a.size(); k++) begin
      checks++; if (wr_a[k] != k || wr_d[k] != 8 || wr_d[k] != int'(ref_result(k))) begin
        failures++; $display("[TB] FAIL basic_wr[%0d] got=(%0d,%0d) exp=(%0d,8)", k, wr_a[k], wr_d[k], k); end
    end
    checks++; if (dn_c.size() != 1 || wr_c.size() != NN || dn_c[0] != t0 + LAT || wr_c[NN-1] != t0 + LAT) begin
      failures++; $display("[TB] FAIL basic_done got=%0d dones, last at %0d exp=1 at %0d", dn_c.size(), dn_c.size() > 0 ? dn_c[0] - t0 : -1, LAT); end
    checks++; if (bz_c.size() != LAT || bz_c[0] != t0 + 1) begin
      failures++; $display("[TB] FAIL basic_busy got=%0d cycles exp=%0d", bz_c.size(), LAT); end
  endtask

  // Acts 1..5, neuron0 weights -8, neuron1 weights 7: ReLU floor then 105>>>6
  task automatic test_relu();
    for (int i = 0; i < NI; i++) write_act(i, i + 1);
    for (int k = 0; k < NI; k++) begin wmem[k] = 4'b1000; wmem[NI+k] = 4'd7; end
    run_layer(0, 0, 0, 0, 0, 0);
    checks++; if (wr_d.size() != 2 || wr_d[0] != 0 || wr_d[1] != 1) begin
      failures++; $display("[TB] FAIL relu_results got=%0d writes (%0d,%0d) exp=2 writes (0,1)", wr_d.size(), wr_d.size() > 0 ? wr_d[0] : -1, wr_d.size() > 1 ? wr_d[1] : -1); end
  endtask

  // Repeated start and an activation write mid-layer are ignored
  task automatic test_ignore_busy();
    for (int i = 0; i < NI; i++) write_act(i, 15);
    for (int k = 0; k < NI*NN; k++) wmem[k] = 4'd7;
    run_layer(0, 0, 3, 4, 0, 3);
    checks++; if (timed_out || dn_c.size() != 1 || dn_c[0] != t0 + LAT) begin
      failures++; $display("[TB] FAIL busy_done got=%0d dones exp=1 at %0d", dn_c.size(), LAT); end
    checks++; if (wr_d.size() != NN || wr_d[0] != 8 || wr_d[1] != 8) begin
      failures++; $display("[TB] FAIL busy_results got=%0d writes exp=%0d writes of 8", wr_d.size(), NN); end
    for (int k = 0; k < pr_d.size(); k++) begin
      checks++; if (pr_d[k] != int'(act_ref[k % NI])) begin
        failures++; $display("[TB] FAIL busy_buffer[%0d] got=%0d exp=%0d", k, pr_d[k], act_ref[k % NI]); end
    end
  endtask

  // Reset at T+5 aborts; buffer survives so a fresh start repeats scenario 1
  task automatic test_reset_mid();
    clear_logs();
    @(posedge clk); #1; start = 1'b1; t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, w_rd_en, nrn_valid, out_wr_en, w_rd_addr, nrn_data, nrn_weight, out_wr_addr, out_wr_data} !== '0) begin
      failures++; $display("[TB] FAIL midreset_outputs got=%0h exp=0", {busy, done, w_rd_en, nrn_valid, out_wr_en, w_rd_addr, nrn_data, nrn_weight, out_wr_addr, out_wr_data}); end
    repeat (20) @(negedge clk);
    checks++; if (dn_c.size() != 0 || wr_c.size() != 0) begin
      failures++; $display("[TB] FAIL midreset_quiet got=%0d dones %0d writes exp=0 0", dn_c.size(), wr_c.size()); end
    run_layer(0, 0, 0, 0, 0, 0);
    checks++; if (timed_out || dn_c.size() != 1 || wr_d.size() != NN || wr_d[0] != 8 || wr_d[1] != 8) begin
      failures++; $display("[TB] FAIL midreset_rerun got=%0d writes %0d dones exp=%0d writes of 8, 1 done", wr_d.size(), dn_c.size(), NN); end
  endtask

`ifdef LAYER_FEEDER_PAUSE_EN
  // Pause for T+3..T+5: gapless addresses, 3-cycle valid gap, done 3 later
  task automatic test_pause();
    run_layer(3, 3, 0, 0, 0, 0);
    checks++; if (rd_a.size() != NI*NN) begin
      failures++; $display("[TB] FAIL pause_rd_count got=%0d exp=%0d", rd_a.size(), NI*NN); end
    for (int k = 0; k < rd_a.size(); k++) begin
      checks++; if (rd_a[k] != k || rd_c[k] != t0 + 1 + k + (k >= 2 ? 3 : 0)) begin
        failures++; $display("[TB] FAIL pause_rd[%0d] got=addr %0d@%0d exp=addr %0d@%0d", k, rd_a[k], rd_c[k] - t0, k, 1 + k + (k >= 2 ? 3 : 0)); end
    end
    checks++; if (nv_c.size() != NI*NN || nv_c[2] - nv_c[1] != 4) begin
      failures++; $display("[TB] FAIL pause_nv_gap got=%0d pairs exp=%0d with 3-cycle gap", nv_c.size(), NI*NN); end
    checks++; if (timed_out || dn_c.size() != 1 || dn_c[0] != t0 + LAT + 3 || wr_d.size() != NN || wr_d[1] != 8) begin
      failures++; $display("[TB] FAIL pause_done got=%0d dones exp=1 at %0d", dn_c.size(), LAT + 3); end
  endtask
`endif

  // Writes to rows >= NI are dropped
  task automatic test_out_of_range();
    for (int a = NI; a < (1 << A_W); a++) write_act(a, 9);
    run_layer(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < pr_d.size(); k++) begin
      checks++; if (pr_d[k] != 15) begin
        failures++; $display("[TB] FAIL oor_buffer[%0d] got=%0d exp=15", k, pr_d[k]); end
    end
    checks++; if (wr_d.size() != NN || wr_d[0] != 8 || wr_d[1] != 8) begin
      failures++; $display("[TB] FAIL oor_results got=%0d writes exp=%0d writes of 8", wr_d.size(), NN); end
  endtask

  // A result strobe while idle must not write nor advance the result index
  task automatic test_idle_result();
    @(posedge clk); #1; inj_v = 1'b1; inj_d = 4'd9;
    @(posedge clk); #1; inj_v = 1'b0;
    @(negedge clk);
    checks++; if (out_wr_en !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_result got=%b exp=0", out_wr_en); end
    run_layer(0, 0, 0, 0, 0, 0);
    checks++; if (wr_a.size() != NN || wr_a[0] != 0 || wr_a[1] != 1) begin
      failures++; $display("[TB] FAIL idle_result_addr got=%0d writes exp=addresses 0,1", wr_a.size()); end
  endtask

  // Random activations and weights across several layers
  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) write_act(i, int'($urandom_range(0, 15)));
      for (int k = 0; k < NI*NN; k++) wmem[k] = 4'($urandom_range(0, 15));
      run_layer(0, 0, 0, 0, 0, 0);
      checks++; if (timed_out || dn_c.size() != 1 || wr_d.size() != NN) begin
        failures++; $display("[TB] FAIL rand%0d_shape got=%0d dones %0d writes exp=1 %0d", r, dn_c.size(), wr_d.size(), NN); end
      for (int k = 0; k < pr_d.size(); k++) begin
        checks++; if (pr_d[k] != int'(act_ref[k % NI]) || pr_w[k] != int'(wmem[k])) begin
          failures++; $display("[TB] FAIL rand%0d_pair[%0d] got=(%0d,%0d) exp=(%0d,%0d)", r, k, pr_d[k], pr_w[k], act_ref[k % NI], wmem[k]); end
      end
      for (int k = 0; k < wr_d.size(); k++) begin
        checks++; if (wr_a[k] != k || wr_d[k] != int'(ref_result(k))) begin
          failures++; $display("[TB] FAIL rand%0d_wr[%0d] got=(%0d,%0d) exp=(%0d,%0d)", r, k, wr_a[k], wr_d[k], k, ref_result(k)); end
      end
    end
  endtask

  // Start coinciding with done is ignored; the next cycle's start is taken
  task automatic test_back_to_back();
    clear_logs();
    @(posedge clk); #1; start = 1'b1; t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < t0 + LAT) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    checks++; if (dn_c.size() != 1 || dn_c[0] != t0 + LAT) begin
      failures++; $display("[TB] FAIL b2b_first_done got=%0d dones exp=1 at %0d", dn_c.size(), LAT); end
    checks++; if ({busy, w_rd_en} !== 2'b00) begin
      failures++; $display("[TB] FAIL b2b_start_on_done got=%b exp=00", {busy, w_rd_en}); end
    run_layer(0, 0, 0, 0, 0, 0);
    checks++; if (timed_out || dn_c.size() != 1 || dn_c[0] != t0 + LAT || wr_d.size() != NN || wr_d[1] != int'(ref_result(1))) begin
      failures++; $display("[TB] FAIL b2b_second got=%0d dones %0d writes exp=1 %0d", dn_c.size(), wr_d.size(), NN); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_ignore_busy();
    test_reset_mid();
`ifdef LAYER_FEEDER_PAUSE_EN
    test_pause();
`endif
    test_out_of_range();
    test_idle_result();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
